// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // Round-robin advance; the 2-bit width makes 3 -> 0 wrap naturally.
  function automatic ch_idx_t next_rr(input ch_idx_t p);
    return ch_idx_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// One-entry holding register for a single output channel with valid/ready handshake.
module demux_ch_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         out_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  // A load wins over a drain so a same-cycle refill keeps valid high with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && out_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: steers accepted words by in_sel or a strict
// round-robin pointer into four independently drained holding registers.
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                rr_en,
  output logic [SEL_W-1:0]    rr_ptr,
  output logic [NUM_CH*W-1:0] out_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready
);

  ch_idx_t           target;
  ch_idx_t           rr_q;
  logic              accept;
  logic [NUM_CH-1:0] load;

  // Target space is checked only at its own channel, so a stalled neighbour never blocks.
  always_comb begin
    target   = rr_en ? rr_q : ch_idx_t'(in_sel);
    in_ready = !rst && (!out_valid[target] || out_ready[target]);
    accept   = in_valid && in_ready;
    load     = '0;
    load[target] = accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (accept && rr_en) begin
      rr_q <= next_rr(rr_q);
    end
  end

  assign rr_ptr = rr_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux_ch_reg #(.W(W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .din       (in_data),
      .out_ready (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (out_data[i*W +: W])
    );
  end

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed self-checking bench for demux_1to4_reg with hand-computed expectations.
module tb_demux_1to4_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        rr_en;
  logic [1:0]  rr_ptr;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  int n_cmp = 0;
  int n_err = 0;

  demux_1to4_reg #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .rr_ptr    (rr_ptr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_sel = 2'd0;
    rr_en = 1'b0; out_ready = 4'h0;
    step();
    step();
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++;
    if (out_valid !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_out_valid got=%b want=0000", out_valid); end
    n_cmp++;
    if (out_data !== 32'h0) begin n_err++; $display("[TB] FAIL reset_out_data got=%h want=00000000", out_data); end
    n_cmp++;
    if (rr_ptr !== 2'd0) begin n_err++; $display("[TB] FAIL reset_rr_ptr got=%0d want=0", rr_ptr); end
    rst = 1'b0; in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 4'b0000) begin n_err++; $display("[TB] FAIL post_reset_idle got=%b want=0000", out_valid); end
  endtask

  task automatic test_select();
    logic [7:0] dat [3] = '{8'hA1, 8'hB2, 8'hC3};
    logic [1:0] sel [3] = '{2'd2, 2'd0, 2'd3};
    rr_en = 1'b0; out_ready = 4'hF;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = dat[k]; in_sel = sel[k];
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL sel_in_ready[%0d] got=%b want=1", k, in_ready); end
      step();
      n_cmp++;
      if (out_valid !== (4'b0001 << sel[k])) begin
        n_err++; $display("[TB] FAIL sel_valid[%0d] got=%b want=%b", k, out_valid, 4'b0001 << sel[k]);
      end
      n_cmp++;
      if (out_data[sel[k]*8 +: 8] !== dat[k]) begin
        n_err++; $display("[TB] FAIL sel_data[%0d] got=%h want=%h", k, out_data[sel[k]*8 +: 8], dat[k]);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 4'b0000) begin n_err++; $display("[TB] FAIL sel_drain got=%b want=0000", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 8'h11; in_sel = 2'd1;
    step();
    n_cmp++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h11) begin
      n_err++; $display("[TB] FAIL bp_hold got=%b/%h want=0010/11", out_valid, out_data[15:8]);
    end
    in_data = 8'h22; in_sel = 2'd1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_stall got=%b want=0", in_ready); end
    step();
    n_cmp++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h11) begin
      n_err++; $display("[TB] FAIL bp_no_overwrite got=%b/%h want=0010/11", out_valid, out_data[15:8]);
    end
    in_data = 8'h33; in_sel = 2'd2;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_other_ready got=%b want=1", in_ready); end
    step();
    n_cmp++;
    if (out_valid !== 4'b0110 || out_data[23:16] !== 8'h33) begin
      n_err++; $display("[TB] FAIL bp_other_load got=%b/%h want=0110/33", out_valid, out_data[23:16]);
    end
    in_valid = 1'b0; out_ready = 4'hF;
    step();
    n_cmp++;
    if (out_valid !== 4'b0000) begin n_err++; $display("[TB] FAIL bp_release got=%b want=0000", out_valid); end
    in_valid = 1'b1; in_data = 8'h22; in_sel = 2'd1;
    step();
    n_cmp++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h22) begin
      n_err++; $display("[TB] FAIL bp_resend got=%b/%h want=0010/22", out_valid, out_data[15:8]);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 4'h0;
    in_valid = 1'b1; in_data = 8'h55; in_sel = 2'd0;
    step();
    n_cmp++;
    if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h55) begin
      n_err++; $display("[TB] FAIL b2b_first got=%b/%h want=1/55", out_valid[0], out_data[7:0]);
    end
    out_ready = 4'b0001; in_data = 8'h66;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ready got=%b want=1", in_ready); end
    step();
    n_cmp++;
    if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h66) begin
      n_err++; $display("[TB] FAIL b2b_refill got=%b/%h want=1/66", out_valid[0], out_data[7:0]);
    end
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid[0] !== 1'b0 || out_data[7:0] !== 8'h66) begin
      n_err++; $display("[TB] FAIL b2b_retain got=%b/%h want=0/66", out_valid[0], out_data[7:0]);
    end
  endtask

  task automatic test_round_robin();
    int ch;
    rr_en = 1'b1; out_ready = 4'hF;
    n_cmp++;
    if (rr_ptr !== 2'd0) begin n_err++; $display("[TB] FAIL rr_start got=%0d want=0", rr_ptr); end
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_data = 8'(k); in_sel = 2'd3;
      ch = (k - 1) % 4;
      step();
      n_cmp++;
      if (out_valid !== (4'b0001 << ch) || out_data[ch*8 +: 8] !== 8'(k)) begin
        n_err++; $display("[TB] FAIL rr_word[%0d] got=%b/%h want=%b/%h", k, out_valid, out_data[ch*8 +: 8], 4'b0001 << ch, 8'(k));
      end
    end
    n_cmp++;
    if (rr_ptr !== 2'd1) begin n_err++; $display("[TB] FAIL rr_wrap_ptr got=%0d want=1", rr_ptr); end
    rr_en = 1'b0; out_ready = 4'b1101; in_data = 8'h07; in_sel = 2'd1;
    step();
    n_cmp++;
    if (rr_ptr !== 2'd1 || out_valid !== 4'b0010) begin
      n_err++; $display("[TB] FAIL rr_sel_keeps_ptr got=%0d/%b want=1/0010", rr_ptr, out_valid);
    end
    rr_en = 1'b1; in_data = 8'h08; in_sel = 2'd2;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rr_stall_ready got=%b want=0", in_ready); end
    step();
    n_cmp++;
    if (rr_ptr !== 2'd1 || out_valid !== 4'b0010 || out_data[15:8] !== 8'h07) begin
      n_err++; $display("[TB] FAIL rr_no_skip got=%0d/%b/%h want=1/0010/07", rr_ptr, out_valid, out_data[15:8]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    rr_en = 1'b0; out_ready = 4'h0;
    in_valid = 1'b1; in_data = 8'h90; in_sel = 2'd0;
    step();
    in_data = 8'h93; in_sel = 2'd3;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 4'b1011) begin n_err++; $display("[TB] FAIL mid_setup got=%b want=1011", out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL mid_rst_ready got=%b want=0", in_ready); end
    step();
    n_cmp++;
    if (out_valid !== 4'b0000 || rr_ptr !== 2'd0 || out_data !== 32'h0) begin
      n_err++; $display("[TB] FAIL mid_rst got=%b/%0d/%h want=0000/0/00000000", out_valid, rr_ptr, out_data);
    end
    rst = 1'b0; out_ready = 4'hF;
    step();
    step();
    n_cmp++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
      n_err++; $display("[TB] FAIL mid_no_reappear got=%b/%h want=0000/00000000", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1to4_reg.md
Name: demux_1to4_reg

Overview:
Registered 1-to-4 demultiplexer, the steering counterpart to the team's 4-to-1 selector.
- Accepts one W-bit input stream with valid/ready handshake.
- Routes each accepted word to one of four output channels, chosen either by an explicit select or by a round-robin pointer.
- Each channel has a one-entry holding register with its own valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits between a single producer and four downstream consumers.

Parameters:
- W, 8, data width of input and of each output channel.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  W  input word.
- in_sel  input  2  target channel when rr_en=0.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- rr_en  input  1  1 = round-robin steering, 0 = steer by in_sel.
- rr_ptr  output  2  current round-robin target.
- out_data  output  4*W  channel i occupies bits [i*W +: W].
- out_valid  output  4  channel i holds a word.
- out_ready  input  4  consumer i takes the word this cycle.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values (at the first clk edge with rst=1): out_valid=0, out_data=0, rr_ptr=0. While rst=1, in_ready is forced to 0 and nothing is accepted.
- Reset mid-operation discards all held words. No out_valid is asserted in the cycle after rst is released unless an accept occurs in that cycle.
- Target: t = rr_en ? rr_ptr : in_sel.
- in_ready = !rst && (!out_valid[t] || out_ready[t]). This is combinational from out_ready[t], giving full throughput when a channel drains every cycle.
- Accept (in_valid && in_ready) at edge k causes:
  - data_q[t] <= in_data;
  - out_valid[t] = 1 from cycle k+1;
  - latency is exactly 1 cycle.
- Drain: when out_valid[i] && out_ready[i] at an edge and channel i is not loaded at that edge, out_valid[i] <= 0.
- Simultaneous drain and load on the same channel: out_valid stays 1 and data_q takes the new word. No bubble, no loss.
- data_q[i] changes only on load. out_data[i] retains its last value after drain and is never cleared except by rst.
- out_valid[i] never depends combinationally on out_ready[i]. Once asserted, it stays asserted with stable data until drained.
- Channels drain independently. A full, stalled channel never blocks accepts targeting other channels.
- Round-robin:
  - rr_ptr increments by 1, wrapping 3 -> 0, on each accept while rr_en=1.
  - It is unchanged when rr_en=0 or when there is no accept.
  - Toggling rr_en does not reset rr_ptr.
  - Rotation is strict: if channel rr_ptr is full and not draining, in_ready=0 and the block stalls. It does not skip ahead.
- If in_sel, rr_en or in_data change while in_valid=1 and in_ready=0, there is no error. The target is re-evaluated every cycle.
- Ordering: words sent to the same channel emerge in acceptance order.

Decomposition:
- Package demux_pkg:
  - NUM_CH=4;
  - SEL_W=2;
  - typedef ch_idx_t (SEL_W bits);
  - function next_rr(ch_idx_t), providing the wrap increment.
- Sub-module demux_ch_reg: a one-entry holding register with load and out_ready inputs, producing valid and data. It is instantiated NUM_CH times via generate.
- The top level holds target select, in_ready logic and the rr_ptr register.

Test Plan:
1. Reset and idle: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=4'b0000, out_data=0, rr_ptr=0.
2. Select steering: rr_en=0, all out_ready=1; send 0xA1 sel=2, 0xB2 sel=0, 0xC3 sel=3 on consecutive cycles -> out_valid pulses 4'b0100, 4'b0001, 4'b1000 one cycle after each send, with matching data; in_ready held 1 throughout.
3. Back-pressure isolation:
   - Setup: out_ready[1]=0; send 0x11 sel=1, then 0x22 sel=1, then 0x33 sel=2.
   - Response: ch1 holds 0x11; in_ready=0 while 0x22 is presented.
   - Switch sel to 2: 0x33 is accepted and appears on ch2.
   - Raise out_ready[1]: 0x11 drains, and a resent 0x22 appears next.
4. Simultaneous drain and load: ch0 full with 0x55, out_ready[0]=1, send 0x66 sel=0 -> out_valid[0] stays 1; out_data ch0 reads 0x66 the next cycle with no gap.
5. Round-robin wrap and stall:
   - Setup: rr_en=1, all out_ready=1; send 5 words 0x01..0x05.
   - Required response: they land on ch0, 1, 2, 3, 0; rr_ptr ends at 1.
   - Then set out_ready[1]=0 with ch1 full: in_ready=0 and rr_ptr stays at 1.
6. Reset mid-operation: channels 0 and 3 full, assert rst for 1 cycle -> out_valid=0 and rr_ptr=0 next cycle; held words never reappear.
